// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register for the RV32I core: captures the decode bundle, forwards
// EX/MEM and MEM/WB results into the ALU operands, and flags load-use hazards.
module ex_operand_stage #(
  parameter int DATAW = 32,
  parameter int REGW  = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic             i_id_valid,
  input  logic [DATAW-1:0] i_id_pc,
  input  logic [DATAW-1:0] i_id_imm,
  input  logic [REGW-1:0]  i_id_rs1,
  input  logic [REGW-1:0]  i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [DATAW-1:0] i_id_rs1_data,
  input  logic [DATAW-1:0] i_id_rs2_data,
  input  logic [3:0]       i_id_alu_sel,
  input  logic [1:0]       i_id_a_sel,
  input  logic [1:0]       i_id_b_sel,
  input  logic [REGW-1:0]  i_id_rd,
  input  logic             i_id_wen,
  input  logic             i_id_is_load,
  input  logic [REGW-1:0]  i_exm_rd,
  input  logic             i_exm_wen,
  input  logic [DATAW-1:0] i_exm_data,
  input  logic [REGW-1:0]  i_mwb_rd,
  input  logic             i_mwb_wen,
  input  logic [DATAW-1:0] i_mwb_data,
  output logic [3:0]       o_alu_sel,
  output logic [DATAW-1:0] o_alu_a,
  output logic [DATAW-1:0] o_alu_b,
  output logic [DATAW-1:0] o_ex_store_data,
  output logic             o_ex_valid,
  output logic [REGW-1:0]  o_ex_rd,
  output logic             o_ex_wen,
  output logic             o_ex_is_load,
  output logic [DATAW-1:0] o_ex_pc,
  output logic             o_load_use_stall
);

  localparam logic [3:0] ALU_ADD = 4'd0;

  logic             r_valid;
  logic [REGW-1:0]  r_rd;
  logic             r_wen;
  logic             r_is_load;
  logic [DATAW-1:0] r_pc;
  logic [3:0]       r_alu_sel;
  logic [1:0]       r_a_sel;
  logic [1:0]       r_b_sel;
  logic [REGW-1:0]  r_rs1;
  logic [REGW-1:0]  r_rs2;
  logic [DATAW-1:0] r_rs1_data;
  logic [DATAW-1:0] r_rs2_data;
  logic [DATAW-1:0] r_imm;

  logic             w_load_use_raw;
  logic             w_bubble;
  logic             w_capture;
  logic [DATAW-1:0] w_fwd_rs1;
  logic [DATAW-1:0] w_fwd_rs2;

  // Youngest producer wins; x0 is never bypassed.
  function automatic logic [DATAW-1:0] fwd_value(
    input logic [REGW-1:0]  rs,
    input logic [DATAW-1:0] reg_val,
    input logic [REGW-1:0]  exm_rd,
    input logic             exm_wen,
    input logic [DATAW-1:0] exm_data,
    input logic [REGW-1:0]  mwb_rd,
    input logic             mwb_wen,
    input logic [DATAW-1:0] mwb_data
  );
    logic [DATAW-1:0] v;
    if (rs == '0) begin
      v = reg_val;
    end else if (exm_wen && (exm_rd == rs)) begin
      v = exm_data;
    end else if (mwb_wen && (mwb_rd == rs)) begin
      v = mwb_data;
    end else begin
      v = reg_val;
    end
    return v;
  endfunction

  assign w_load_use_raw = r_valid && r_is_load && (r_rd != '0) && i_id_valid &&
                          ((i_id_use_rs1 && (i_id_rs1 == r_rd)) ||
                           (i_id_use_rs2 && (i_id_rs2 == r_rd)));
  assign w_bubble  = !i_rst_n || i_flush || (!i_stall && w_load_use_raw);
  assign w_capture = !w_bubble && !i_stall;

  // ID/EX bundle register: bubble on reset/flush/load-use, hold on stall.
  always_ff @(posedge i_clk) begin
    if (w_bubble) begin
      r_valid    <= 1'b0;
      r_rd       <= '0;
      r_wen      <= 1'b0;
      r_is_load  <= 1'b0;
      r_pc       <= '0;
      r_alu_sel  <= ALU_ADD;
      r_a_sel    <= 2'd0;
      r_b_sel    <= 2'd0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
    end else if (w_capture) begin
      r_valid    <= i_id_valid;
      r_rd       <= i_id_rd;
      r_wen      <= i_id_wen && i_id_valid;
      r_is_load  <= i_id_is_load && i_id_valid;
      r_pc       <= i_id_pc;
      r_alu_sel  <= i_id_alu_sel;
      r_a_sel    <= i_id_a_sel;
      r_b_sel    <= i_id_b_sel;
      r_rs1      <= i_id_rs1;
      r_rs2      <= i_id_rs2;
      r_rs1_data <= i_id_rs1_data;
      r_rs2_data <= i_id_rs2_data;
      r_imm      <= i_id_imm;
    end
  end

  assign w_fwd_rs1 = fwd_value(r_rs1, r_rs1_data, i_exm_rd, i_exm_wen, i_exm_data,
                               i_mwb_rd, i_mwb_wen, i_mwb_data);
  assign w_fwd_rs2 = fwd_value(r_rs2, r_rs2_data, i_exm_rd, i_exm_wen, i_exm_data,
                               i_mwb_rd, i_mwb_wen, i_mwb_data);

  // Operand A select; the reserved code reads as zero.
  always_comb begin
    o_alu_a = '0;
    case (r_a_sel)
      2'd0:    o_alu_a = w_fwd_rs1;
      2'd1:    o_alu_a = r_pc;
      default: o_alu_a = '0;
    endcase
  end

  // Operand B select; the reserved code reads as zero.
  always_comb begin
    o_alu_b = '0;
    case (r_b_sel)
      2'd0:    o_alu_b = w_fwd_rs2;
      2'd1:    o_alu_b = r_imm;
      2'd2:    o_alu_b = DATAW'(4);
      default: o_alu_b = '0;
    endcase
  end

  assign o_ex_store_data  = w_fwd_rs2;
  assign o_alu_sel        = r_alu_sel;
  assign o_ex_valid       = r_valid;
  assign o_ex_rd          = r_rd;
  assign o_ex_wen         = r_wen;
  assign o_ex_is_load     = r_is_load;
  assign o_ex_pc          = r_pc;
  assign o_load_use_stall = w_load_use_raw && !i_stall && !i_flush;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: directed hazard scenarios then random traffic,
// checked against a bundle-level reference model.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush;
  logic        id_valid, id_use_rs1, id_use_rs2, id_wen, id_is_load;
  logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_sel;
  logic [1:0]  id_a_sel, id_b_sel;
  logic [4:0]  exm_rd, mwb_rd;
  logic        exm_wen, mwb_wen;
  logic [31:0] exm_data, mwb_data;
  logic [3:0]  alu_sel;
  logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
  logic        ex_valid, ex_wen, ex_is_load, load_use_stall;
  logic [4:0]  ex_rd;

  ex_operand_stage #(.DATAW(32), .REGW(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush),
    .i_id_valid(id_valid), .i_id_pc(id_pc), .i_id_imm(id_imm),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
    .i_id_rs1_data(id_rs1_data), .i_id_rs2_data(id_rs2_data), .i_id_alu_sel(id_alu_sel),
    .i_id_a_sel(id_a_sel), .i_id_b_sel(id_b_sel), .i_id_rd(id_rd), .i_id_wen(id_wen),
    .i_id_is_load(id_is_load), .i_exm_rd(exm_rd), .i_exm_wen(exm_wen), .i_exm_data(exm_data),
    .i_mwb_rd(mwb_rd), .i_mwb_wen(mwb_wen), .i_mwb_data(mwb_data),
    .o_alu_sel(alu_sel), .o_alu_a(alu_a), .o_alu_b(alu_b), .o_ex_store_data(ex_store_data),
    .o_ex_valid(ex_valid), .o_ex_rd(ex_rd), .o_ex_wen(ex_wen), .o_ex_is_load(ex_is_load),
    .o_ex_pc(ex_pc), .o_load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  // Instruction as held in EX by the reference model.
  typedef struct packed {
    logic v, wen, ld;
    logic [4:0] rd, rs1, rs2;
    logic [31:0] pc, imm, d1, d2;
    logic [3:0] sel;
    logic [1:0] as, bs;
  } instr_t;

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] a, b, sd, pc;
    logic        v;
    logic [4:0]  rd;
    logic        wen, ld, lus;
  } obs_t;

  instr_t m_ex;
  bit     m_known = 1'b0;
  obs_t   sb[$];
  int     errors = 0, checks = 0, cyc = 0;

  // Value of architectural register r seen by EX: newest in-flight writer, else the regfile read.
  function automatic logic [31:0] m_read(input logic [4:0] r, input logic [31:0] regv);
    logic [4:0]  w_rd[2];
    logic        w_en[2];
    logic [31:0] w_d[2];
    w_rd[0] = exm_rd; w_en[0] = exm_wen; w_d[0] = exm_data;
    w_rd[1] = mwb_rd; w_en[1] = mwb_wen; w_d[1] = mwb_data;
    if (r == 5'd0) return regv;
    for (int k = 0; k < 2; k++)
      if (w_en[k] && w_rd[k] == r) return w_d[k];
    return regv;
  endfunction

  function automatic bit m_hazard();
    return m_ex.v && m_ex.ld && m_ex.rd != 5'd0 && id_valid &&
           ((id_use_rs1 && id_rs1 == m_ex.rd) || (id_use_rs2 && id_rs2 == m_ex.rd));
  endfunction

  function automatic obs_t m_expect();
    obs_t o;
    logic [31:0] ops_a[4];
    logic [31:0] ops_b[4];
    ops_a = '{m_read(m_ex.rs1, m_ex.d1), m_ex.pc, 32'd0, 32'd0};
    ops_b = '{m_read(m_ex.rs2, m_ex.d2), m_ex.imm, 32'd4, 32'd0};
    o.sel = m_ex.sel;
    o.a   = ops_a[m_ex.as];
    o.b   = ops_b[m_ex.bs];
    o.sd  = m_read(m_ex.rs2, m_ex.d2);
    o.pc  = m_ex.pc;
    o.v   = m_ex.v;
    o.rd  = m_ex.rd;
    o.wen = m_ex.wen;
    o.ld  = m_ex.ld;
    o.lus = m_hazard() && !stall && !flush;
    return o;
  endfunction

  function automatic instr_t m_next();
    instr_t n;
    n = m_ex;
    if (!rst_n || flush || (!stall && m_hazard())) n = '0;
    else if (!stall) begin
      n.v = id_valid; n.wen = id_wen & id_valid; n.ld = id_is_load & id_valid;
      n.rd = id_rd; n.rs1 = id_rs1; n.rs2 = id_rs2; n.pc = id_pc; n.imm = id_imm;
      n.d1 = id_rs1_data; n.d2 = id_rs2_data; n.sel = id_alu_sel;
      n.as = id_a_sel; n.bs = id_b_sel;
    end
    return n;
  endfunction

  // One clock: inputs already driven at the falling edge.
  task automatic step();
    #1;
    if (m_known) sb.push_back(m_expect());
    @(posedge clk);
    if (!rst_n) m_known = 1'b1;
    m_ex = m_next();
    cyc++;
    @(negedge clk);
  endtask

  task automatic rand_id(input int maxreg);
    id_valid    = ($urandom_range(0, 7) != 0);
    id_pc       = $urandom; id_imm = $urandom;
    id_rs1      = 5'($urandom_range(0, maxreg)); id_rs2 = 5'($urandom_range(0, maxreg));
    id_rs1_data = (id_rs1 == 5'd0) ? 32'd0 : $urandom;
    id_rs2_data = (id_rs2 == 5'd0) ? 32'd0 : $urandom;
    id_use_rs1  = 1'($urandom); id_use_rs2 = 1'($urandom);
    id_alu_sel  = 4'($urandom); id_a_sel = 2'($urandom); id_b_sel = 2'($urandom);
    id_rd       = 5'($urandom_range(0, maxreg));
    id_wen      = 1'($urandom); id_is_load = ($urandom_range(0, 2) == 0);
  endtask

  task automatic rand_wb(input int maxreg);
    exm_rd = 5'($urandom_range(0, maxreg)); exm_wen = 1'($urandom); exm_data = $urandom;
    mwb_rd = 5'($urandom_range(0, maxreg)); mwb_wen = 1'($urandom); mwb_data = $urandom;
  endtask

  task automatic present(input logic [4:0] rs1, input logic [31:0] d1, input logic [4:0] rs2,
                         input logic [31:0] d2, input logic [1:0] as, input logic [1:0] bs,
                         input logic [31:0] imm, input logic [4:0] rd, input logic ld);
    id_valid = 1'b1; id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2; id_rs2_data = d2;
    id_a_sel = as; id_b_sel = bs; id_imm = imm; id_rd = rd; id_wen = 1'b1; id_is_load = ld;
    id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; id_pc = $urandom; id_alu_sel = 4'($urandom);
  endtask

  // Monitor: outputs are compared every cycle, away from the clock edge.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = '{alu_sel, alu_a, alu_b, ex_store_data, ex_pc, ex_valid, ex_rd, ex_wen,
              ex_is_load, load_use_stall};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle%0d obs got=%h want=%h", cyc, a, e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    rand_id(31); rand_wb(31);
    @(negedge clk);
    // reset with random decode traffic
    step(); rand_id(31); step();
    rst_n = 1'b1; exm_wen = 1'b0; mwb_wen = 1'b0; id_valid = 1'b0;
    step();
    // EX/MEM beats MEM/WB, then MEM/WB alone
    present(5'd5, 32'h11, 5'd6, 32'h66, 2'd0, 2'd0, 32'd0, 5'd9, 1'b0); step();
    id_valid = 1'b0;
    exm_rd = 5'd5; exm_wen = 1'b1; exm_data = 32'h22;
    mwb_rd = 5'd5; mwb_wen = 1'b1; mwb_data = 32'h33; stall = 1'b1; step();
    exm_wen = 1'b0; step();
    stall = 1'b0; mwb_wen = 1'b0;
    // x0 guard on rs2 with each B select
    exm_rd = 5'd0; exm_wen = 1'b1; exm_data = 32'hFFFF_FFFF;
    present(5'd0, 32'd0, 5'd0, 32'd0, 2'd0, 2'd0, 32'd0, 5'd1, 1'b0); step();
    present(5'd0, 32'd0, 5'd0, 32'd0, 2'd1, 2'd2, 32'd0, 5'd1, 1'b0); step();
    present(5'd0, 32'd0, 5'd0, 32'd0, 2'd3, 2'd1, 32'hFFFF_F800, 5'd1, 1'b0); step();
    present(5'd0, 32'd0, 5'd0, 32'd0, 2'd2, 2'd3, 32'h1234, 5'd1, 1'b0); step();
    exm_wen = 1'b0;
    // load-use: lw x7 then add x8,x7,x1
    present(5'd2, 32'h100, 5'd0, 32'd0, 2'd0, 2'd1, 32'h8, 5'd7, 1'b1); step();
    present(5'd7, 32'hDEAD, 5'd1, 32'h5, 2'd0, 2'd0, 32'd0, 5'd8, 1'b0);
    id_use_rs2 = 1'b1; step();
    step();
    mwb_rd = 5'd7; mwb_wen = 1'b1; mwb_data = 32'hCAFE_0007; id_valid = 1'b0; step();
    mwb_wen = 1'b0;
    // stall and flush together, then a 3-cycle stall with moving bypass data
    present(5'd3, 32'h30, 5'd4, 32'h40, 2'd0, 2'd0, 32'd0, 5'd10, 1'b0); step();
    stall = 1'b1; flush = 1'b1; step();
    stall = 1'b0; flush = 1'b0; step();
    stall = 1'b1; exm_rd = 5'd3; exm_wen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exm_data = $urandom; rand_id(31); step();
    end
    stall = 1'b0; exm_wen = 1'b0;
    // invalid capture must not create a load
    present(5'd1, 32'h1, 5'd1, 32'h1, 2'd0, 2'd0, 32'd0, 5'd7, 1'b1); id_valid = 1'b0; step();
    present(5'd7, 32'h7, 5'd7, 32'h7, 2'd0, 2'd0, 32'd0, 5'd8, 1'b0); step();
    step();
    // randomized traffic with a narrow register range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      rand_id(3); rand_wb(3);
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 49) != 0);
      step();
    end
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-forwarding and operand-select logic for the RV32I core.
- Captures the decoded instruction bundle, resolves data hazards from the EX/MEM and MEM/WB stages, and drives the ALU sel/a/b inputs directly.
- Detects load-use hazards for the decode stage.
- Sits between decode and the ALU.

Parameters:
DATAW, 32, datapath width
REGW, 5, register-address width

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
stall  in  1  hold this stage (downstream memory wait; EX and later stages frozen)
flush  in  1  replace captured instruction with bubble (branch mispredict/trap)
id_valid  in  1  decode bundle valid
id_pc  in  DATAW  instruction PC
id_imm  in  DATAW  sign-extended immediate
id_rs1, id_rs2  in  REGW  source register addresses
id_use_rs1, id_use_rs2  in  1  instruction reads rs1/rs2
id_rs1_data, id_rs2_data  in  DATAW  register-file read data (regfile is write-through)
id_alu_sel  in  4  ALU operation code
id_a_sel  in  2  operand A: 0=rs1, 1=pc, 2=zero, 3=reserved(zero)
id_b_sel  in  2  operand B: 0=rs2, 1=imm, 2=constant 4, 3=reserved(zero)
id_rd  in  REGW  destination register
id_wen  in  1  writes rd
id_is_load  in  1  load instruction
exm_rd  in  REGW  EX/MEM destination
exm_wen  in  1  EX/MEM writes rd (non-load result valid)
exm_data  in  DATAW  EX/MEM result
mwb_rd  in  REGW  MEM/WB destination
mwb_wen  in  1  MEM/WB writes rd
mwb_data  in  DATAW  MEM/WB writeback value
alu_sel  out  4  to ALU
alu_a, alu_b  out  DATAW  to ALU
ex_store_data  out  DATAW  forwarded rs2 value
ex_valid, ex_rd, ex_wen, ex_is_load, ex_pc  out  -  registered bundle fields
load_use_stall  out  1  to hazard unit; holds IF/ID

Behaviour:
- Reset (rst_n=0 at posedge): every register cleared: ex_valid=0, ex_wen=0, ex_is_load=0, ex_rd=0, ex_pc=0, alu_sel=ALU_ADD encoding, registered operands/selects=0. Result: alu_a=0, alu_b=0, ex_store_data=0, load_use_stall=0. Reset mid-stall or mid-hazard discards the held instruction.
- Register update priority at each posedge: reset > flush > stall > load_use_stall > capture.
  - flush: load a bubble (all fields zero, valid=0, wen=0), even if stall is also high.
  - stall: hold all registers.
  - load_use_stall (stall=0): load a bubble; decode holds and re-presents the instruction.
  - capture: register all id_* fields; ex_valid=id_valid. If id_valid=0, wen and is_load are forced to 0.
- Forwarding is combinational from registered rs1/rs2, evaluated every cycle including during stall.
  - fwd_rs1 = exm_data if exm_wen and exm_rd==rs1 and rs1!=0.
  - Otherwise fwd_rs1 = mwb_data if mwb_wen and mwb_rd==rs1 and rs1!=0.
  - Otherwise fwd_rs1 = registered rs1_data.
  - Same rules for rs2. EX/MEM has priority over MEM/WB. x0 is never forwarded and always reads its registered value (0).
- alu_a and alu_b are muxed from the forwarded values per the registered a_sel/b_sel. The constant 4 is zero-extended to DATAW.
- ex_store_data = fwd_rs2, independent of b_sel.
- alu_sel is the registered id_alu_sel. Latency: a decode bundle appears at the ALU 1 cycle after capture.
- load_use_stall = ex_valid & ex_is_load & ex_rd!=0 & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)). Purely combinational.
  - flush overrides it, and so does stall.
  - It clears after the bubble enters because ex_valid becomes 0. The second-cycle dependency is then satisfied via MEM/WB forwarding.
- No arithmetic in this block. Widths are exact; no truncation except the constant 4.

Test Plan:
- Reset: assert rst_n=0 for 2 cycles with random id_* inputs -> ex_valid=0, alu_a=0, alu_b=0, alu_sel=ALU_ADD, load_use_stall=0.
- EX/MEM forwarding priority: registered rs1=x5, rs1_data=0x11; exm_rd=5 exm_data=0x22; mwb_rd=5 mwb_data=0x33; a_sel=0 -> alu_a=0x22. Drop exm_wen -> alu_a=0x33.
- x0 guard: rs2=x0, exm_rd=0, exm_wen=1, exm_data=0xFFFF_FFFF, b_sel=0 -> alu_b=0. b_sel=2 -> alu_b=4. b_sel=1 with imm=0xFFFF_F800 -> alu_b=0xFFFF_F800.
- Load-use: EX holds a load to rd=x7; decode presents add x8,x7,x1 with use_rs1=1 -> load_use_stall=1. Next cycle ex_valid=0 and stall deasserts. The add is then captured and receives mwb_data on alu_a.
- Stall/flush collision: stall=1 and flush=1 together -> bubble captured (ex_valid=0). stall=1 alone for 3 cycles -> all ex_* outputs unchanged while alu_a tracks changing exm_data.
- Invalid capture: id_valid=0, id_wen=1, id_is_load=1 -> ex_wen=0, ex_is_load=0, and no load_use_stall on the following cycle.
